// File: rtl/sum_accumulator.sv
// Accumulates NUM_SAMPLES doubled-sum samples into one block total and hands
// the total, sample count and overflow flag downstream over valid/ready.
module sum_accumulator #(
    parameter int unsigned IN_W        = 9,
    parameter int unsigned ACC_W       = 16,
    parameter int unsigned NUM_SAMPLES = 4,
    parameter int unsigned SATURATE    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [7:0]       out_count,
    output logic             out_ovf
);

    localparam int unsigned SUM_W      = ACC_W + 1;
    localparam logic [7:0]  COUNT_FULL = 8'(NUM_SAMPLES);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_total_q, out_total_d;
    logic [7:0]         out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;
    logic [SUM_W-1:0]   sum_c;

    // Next-state and block bookkeeping; handshake flags are decoded from the next state
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_total_d = out_total_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        sum_c       = SUM_W'(acc_q) + SUM_W'(in_data);

        case (state_q)
            ST_ACCUM: begin
                if (in_valid && in_ready_q) begin
                    if (sum_c[ACC_W]) begin
                        ovf_d = 1'b1;
                        acc_d = (SATURATE != 0) ? '1 : sum_c[ACC_W-1:0];
                    end else begin
                        acc_d = sum_c[ACC_W-1:0];
                    end
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == COUNT_FULL) begin
                        out_total_d = acc_d;
                        out_count_d = COUNT_FULL;
                        out_ovf_d   = ovf_d;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    cnt_d   = 8'd0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase

        // Abort drops the partial block and any pending output but keeps the output payload
        if (clear) begin
            state_d     = ST_ACCUM;
            acc_d       = '0;
            cnt_d       = 8'd0;
            ovf_d       = 1'b0;
            out_total_d = out_total_q;
            out_count_d = out_count_q;
            out_ovf_d   = out_ovf_q;
        end

        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= 8'd0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_total_q <= '0;
            out_count_q <= 8'd0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_total_q <= out_total_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_total = out_total_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
